hazard_ctrl_mc: RTL and testbench
=================================

Name: hazard_ctrl_mc

Overview:
- Successor to the 5-stage pipeline's forwarding-only hazard unit.
- Keeps the EX-stage operand forwarding.
- Adds load-use stalling, branch/jump flushing and whole-pipeline freeze while the data memory is busy.
- A small FSM plus counter supports load-use bubbles of more than one cycle, for slower data memories.
- Sits beside the fetch/decode/execute/mem/writeback stages and drives their stall/flush controls and the EX operand mux selects.

Parameters:
- REG_AW, 5, register address width; address 0 is hardwired zero and never forwarded or matched.
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- Rs1D  in  REG_AW  decode-stage source 1
- Rs2D  in  REG_AW  decode-stage source 2
- Rs1E  in  REG_AW  execute-stage source 1
- Rs2E  in  REG_AW  execute-stage source 2
- RdE  in  REG_AW  execute-stage destination
- RdM  in  REG_AW  memory-stage destination
- RdW  in  REG_AW  writeback-stage destination
- MemReadE  in  1  instruction in EX is a load (ResultSrcE==2'b01)
- RegWriteM  in  1  memory-stage register write enable
- RegWriteW  in  1  writeback-stage register write enable
- PCSrcE  in  1  taken branch or jump resolved in EX
- MemBusyM  in  1  data memory not ready this cycle
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- StallE  out  1  hold ID/EX register
- StallM  out  1  hold EX/MEM register
- FlushD  out  1  clear IF/ID to NOP
- FlushE  out  1  clear ID/EX to NOP
- ForwardAE  out  2  SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
- ForwardBE  out  2  SrcB select, same encoding as ForwardAE

Behaviour:
- Forwarding is combinational.
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise ForwardAE=00.
  - ForwardBE uses the same rules with Rs2E.
  - The M match always wins over the W match.
- Load-use detect: lu = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states: IDLE, LOAD_STALL, MEM_WAIT. Registered state; 3-bit registered counter lu_cnt.
- Priority in every cycle, highest first: rst > MemBusyM > PCSrcE > load-use.
- MemBusyM=1:
  - StallF=StallD=StallE=StallM=1; FlushD=FlushE=0.
  - PCSrcE is ignored; EX is held, so the redirect is taken once the pipeline advances.
  - Next state MEM_WAIT; lu_cnt is frozen.
  - When MemBusyM falls, return to the state saved on entry: LOAD_STALL if lu_cnt!=0, else IDLE.
- IDLE with PCSrcE=1: FlushD=FlushE=1, no stalls, stay IDLE.
- IDLE with lu=1 and PCSrcE=0:
  - StallF=StallD=1, FlushE=1.
  - lu_cnt <= LOAD_USE_CYCLES-1.
  - Go to LOAD_STALL if that value is nonzero, else stay IDLE.
- LOAD_STALL:
  - StallF=StallD=FlushE=1; lu_cnt decrements each cycle; go to IDLE when lu_cnt reaches 0.
  - If PCSrcE=1 (an older branch resolves): FlushD=FlushE=1, StallF=StallD=0, lu_cnt <= 0, go to IDLE.
- A new lu detect while in LOAD_STALL does not reload lu_cnt.
- StallE and StallM are 1 only under MemBusyM.
- Latency: all stall/flush/forward outputs are combinational from inputs and current state, with zero cycles of latency.
- Reset:
  - While rst=1: all Stall*/Flush* outputs are 0, Forward* are 00, state IDLE, lu_cnt 0.
  - Reset asserted mid-stall abandons the stall at the next edge.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cycles[CNT_W-1:0] and flush_events[CNT_W-1:0], both registered and reset to 0.
  - stall_cycles increments on every cycle StallF=1.
  - flush_events increments on every cycle FlushD=1.
  - Both wrap modulo 2^CNT_W.
- When undefined: the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Forwarding, x0 and M/W priority:
  - RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10.
  - Same inputs with RegWriteM=0 -> ForwardAE=01.
  - Rs2E=0, RdM=0 -> ForwardBE=00.
- Load-use, LOAD_USE_CYCLES=1:
  - Stimulus: MemReadE=1, RdE=7, Rs2D=7.
  - Response: StallF=StallD=FlushE=1 for exactly 1 cycle, then all 0; state returns to IDLE.
- Load-use, LOAD_USE_CYCLES=3:
  - Same stimulus -> StallF/StallD/FlushE high for exactly 3 consecutive cycles.
  - Repeat with PCSrcE=1 in the 2nd stall cycle -> that cycle FlushD=FlushE=1, StallF=0; next cycle idle.
- Memory wait:
  - MemBusyM=1 for 4 cycles during LOAD_STALL with lu_cnt=1 -> all four Stall*=1 and no flush for those 4 cycles.
  - After release: exactly 1 more load stall cycle.
- Branch under busy:
  - PCSrcE=1 and MemBusyM=1 together -> FlushD=0.
  - First cycle after MemBusyM drops, PCSrcE=1 -> FlushD=FlushE=1.
- Reset and counters:
  - rst=1 in the 2nd cycle of a 3-cycle stall -> next cycle all outputs 0.
  - With HAZARD_PERF_CNT_EN and CNT_W=4: 17 stall cycles -> stall_cycles=1.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: hazard control for the 5-stage pipeline.
// Provides EX operand forwarding, multi-cycle load-use stalls,
// branch/jump flushing and a whole-pipeline freeze while the data
// memory is busy.
// Optional build macro HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_events performance counters.
module hazard_ctrl_mc #(
  parameter int REG_AW          = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              MemReadE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MemBusyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
`endif
);

  // Out-of-range configurations are rejected at elaboration.
  if (LOAD_USE_CYCLES < 1 || LOAD_USE_CYCLES > 7 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl_mc: LOAD_USE_CYCLES must be 1..7 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  // Counter reload value: remaining stall cycles after the detect cycle.
  localparam logic [2:0] LU_INIT = 3'(LOAD_USE_CYCLES - 1);

  state_t     state, state_nx, state_eff;
  logic [2:0] lu_cnt, lu_cnt_nx;
  logic       lu;

  // Forward select for one EX source: the younger M result wins over W,
  // and x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdm,
    input logic              wem,
    input logic [REG_AW-1:0] rdw,
    input logic              wew
  );
    if (wem && (rdm != '0) && (rdm == rs))      fwd_sel = 2'b10;
    else if (wew && (rdw != '0) && (rdw == rs)) fwd_sel = 2'b01;
    else                                        fwd_sel = 2'b00;
  endfunction

  // Load in EX whose destination is read by the instruction in decode.
  assign lu = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // State and load-use counter register; reset abandons any stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lu_cnt <= 3'd0;
    end else begin
      state  <= state_nx;
      lu_cnt <= lu_cnt_nx;
    end
  end

  // Next-state and stall/flush/forward decode, priority rst > busy > branch > load-use.
  always_comb begin
    state_nx  = state;
    lu_cnt_nx = lu_cnt;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    // MEM_WAIT resumes the interrupted state in the same cycle the memory
    // releases, so no dead cycle is inserted after the freeze.
    if (state == MEM_WAIT) state_eff = (lu_cnt != 3'd0) ? LOAD_STALL : IDLE;
    else                   state_eff = state;

    if (rst) begin
      state_nx  = IDLE;
      lu_cnt_nx = 3'd0;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      if (MemBusyM) begin
        // Freeze everything; a pending redirect stays in EX until release.
        StallF   = 1'b1;
        StallD   = 1'b1;
        StallE   = 1'b1;
        StallM   = 1'b1;
        state_nx = MEM_WAIT;
      end else if (state_eff == LOAD_STALL) begin
        if (PCSrcE) begin
          // The older branch kills the stalled consumer anyway.
          FlushD    = 1'b1;
          FlushE    = 1'b1;
          lu_cnt_nx = 3'd0;
          state_nx  = IDLE;
        end else begin
          StallF    = 1'b1;
          StallD    = 1'b1;
          FlushE    = 1'b1;
          lu_cnt_nx = lu_cnt - 3'd1;
          state_nx  = (lu_cnt <= 3'd1) ? IDLE : LOAD_STALL;
        end
      end else begin
        state_nx = IDLE;
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lu) begin
          StallF    = 1'b1;
          StallD    = 1'b1;
          FlushE    = 1'b1;
          lu_cnt_nx = LU_INIT;
          state_nx  = (LU_INIT != 3'd0) ? LOAD_STALL : IDLE;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters, wrapping at their width.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      stall_cycles <= stall_cycles + CNT_W'(StallF);
      flush_events <= flush_events + CNT_W'(FlushD);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Testbench for hazard_ctrl_mc: two instances (1 and 3 load-use cycles)
// share one stimulus stream; a queue of expected outputs is checked at
// each falling edge.
module tb_hazard_ctrl_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       MemReadE, RegWriteM, RegWriteW, PCSrcE, MemBusyM;

  logic       sf1, sd1, se1, sm1, fd1, fe1;
  logic [1:0] fa1, fb1;
  logic       sf3, sd3, se3, sm3, fd3, fe3;
  logic [1:0] fa3, fb3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fl1;
  logic [3:0]  sc3, fl3;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_AW(5), .LOAD_USE_CYCLES(1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .MemReadE(MemReadE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemBusyM(MemBusyM),
    .StallF(sf1), .StallD(sd1), .StallE(se1), .StallM(sm1), .FlushD(fd1),
    .FlushE(fe1), .ForwardAE(fa1), .ForwardBE(fb1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc1), .flush_events(fl1)
`endif
  );

  hazard_ctrl_mc #(.REG_AW(5), .LOAD_USE_CYCLES(3), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .MemReadE(MemReadE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemBusyM(MemBusyM),
    .StallF(sf3), .StallD(sd3), .StallE(se3), .StallM(sm3), .FlushD(fd3),
    .FlushE(fe3), .ForwardAE(fa3), .ForwardBE(fb3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc3), .flush_events(fl3)
`endif
  );

  // Packed view: {StallF,StallD,StallE,StallM,FlushD,FlushE,ForwardAE,ForwardBE}
  logic [9:0] o1, o3;
  assign o1 = {sf1, sd1, se1, sm1, fd1, fe1, fa1, fb1};
  assign o3 = {sf3, sd3, se3, sm3, fd3, fe3, fa3, fb3};

  localparam logic [9:0] Z  = 10'b0000000000;
  localparam logic [9:0] LS = 10'b1100010000;  // load stall: StallF/D, FlushE
  localparam logic [9:0] BR = 10'b0000110000;  // redirect: FlushD/E
  localparam logic [9:0] BZ = 10'b1111000000;  // memory busy: all stalls

  typedef struct {
    string      tag;
    logic [9:0] e1;
    logic [9:0] e3;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    MemReadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemBusyM = 0;
  endtask

  task automatic lu_stim();
    clr();
    MemReadE = 1; RdE = 7; Rs2D = 7;
  endtask

  // Queue the expectation for the inputs just driven, check it at the
  // falling edge, then step past the next rising edge.
  task automatic chk(input string tag, input logic [9:0] e1, input logic [9:0] e3);
    exp_t e;
    sbq.push_back('{tag, e1, e3});
    @(negedge clk);
    e = sbq.pop_front();
    n_cmp++;
    assert (o1 === e.e1) else begin
      n_fail++;
      $error("FAIL %s u1: observed %b expected %b", e.tag, o1, e.e1);
    end
    n_cmp++;
    assert (o3 === e.e3) else begin
      n_fail++;
      $error("FAIL %s u3: observed %b expected %b", e.tag, o3, e.e3);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    // Reset dominates even with forwarding, branch and busy all active.
    rst = 1; MemBusyM = 1; PCSrcE = 1; RegWriteM = 1; RdM = 5; Rs1E = 5;
    chk("rst_hold", Z, Z);
    rst = 0;

    // Forwarding priority and x0.
    clr(); RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
    chk("fwd_m", 10'b0000001000, 10'b0000001000);
    RegWriteM = 0;
    chk("fwd_w", 10'b0000000100, 10'b0000000100);
    RegWriteM = 1; RdM = 0; Rs2E = 0;
    chk("fwd_x0", 10'b0000000100, 10'b0000000100);
    Rs2E = 5;
    chk("fwd_b", 10'b0000000101, 10'b0000000101);

    // Load-use: 1 bubble on u1, 3 on u3.
    lu_stim();
    chk("lu_c1", LS, LS);
    clr();
    chk("lu_c2", Z, LS);
    chk("lu_c3", Z, LS);
    chk("lu_done", Z, Z);

    // Branch resolving in the 2nd stall cycle.
    lu_stim();
    chk("lub_c1", LS, LS);
    clr(); PCSrcE = 1;
    chk("lub_br", BR, BR);
    clr();
    chk("lub_idle", Z, Z);

    // Memory wait while u3 has one stall cycle left.
    lu_stim();
    chk("mw_c1", LS, LS);
    clr();
    chk("mw_c2", Z, LS);
    MemBusyM = 1;
    for (int i = 0; i < 4; i++) chk("mw_busy", BZ, BZ);
    MemBusyM = 0;
    chk("mw_rel", Z, LS);
    chk("mw_done", Z, Z);

    // Branch held off by busy, taken on release.
    MemBusyM = 1; PCSrcE = 1;
    chk("bb_busy", BZ, BZ);
    MemBusyM = 0;
    chk("bb_rel", BR, BR);
    clr();
    chk("bb_idle", Z, Z);

    // Reset in the 2nd cycle of a 3-cycle stall.
    lu_stim();
    chk("rs_c1", LS, LS);
    clr(); rst = 1;
    chk("rs_assert", Z, Z);
    rst = 0;
    chk("rs_after", Z, Z);

`ifdef HAZARD_PERF_CNT_EN
    // 17 frozen cycles: u3's 4-bit counter wraps to 1.
    clr(); rst = 1;
    chk("pc_rst", Z, Z);
    rst = 0; MemBusyM = 1;
    for (int i = 0; i < 17; i++) chk("pc_busy", BZ, BZ);
    clr();
    n_cmp++;
    assert (sc3 === 4'd1) else begin
      n_fail++; $error("FAIL pc_stall_u3: observed %0d expected 1", sc3);
    end
    n_cmp++;
    assert (sc1 === 32'd17) else begin
      n_fail++; $error("FAIL pc_stall_u1: observed %0d expected 17", sc1);
    end
    n_cmp++;
    assert (fl3 === 4'd0) else begin
      n_fail++; $error("FAIL pc_flush_u3: observed %0d expected 0", fl3);
    end
    PCSrcE = 1;
    chk("pc_br", BR, BR);
    clr();
    n_cmp++;
    assert (fl1 === 32'd1) else begin
      n_fail++; $error("FAIL pc_flush_u1: observed %0d expected 1", fl1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
